// File: rtl/dart_scoreboard.sv
// Dart scoreboard: scores grid throws, accumulates per-player totals over turns, detects the winner.
// Latency 1 cycle from accepted throw to last_score/totals; throw_ready is high only while a game is in play.
// Optional exact-finish bust rule is enabled by defining DART_SCOREBOARD_BUST_EN.
module dart_scoreboard #(
  parameter int W               = 2,
  parameter int NUM_PLAYERS     = 2,
  parameter int THROWS_PER_TURN = 3,
  parameter int TARGET          = 21,
  parameter int SW              = 8,
  localparam int PW = ($clog2(NUM_PLAYERS) > 0) ? $clog2(NUM_PLAYERS) : 1,
  localparam int TW = ($clog2(THROWS_PER_TURN) > 0) ? $clog2(THROWS_PER_TURN) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      throw_valid,
  input  logic [W-1:0]              throw_x,
  input  logic [W-1:0]              throw_y,
  output logic                      throw_ready,
  output logic                      last_valid,
  output logic [W-1:0]              last_score,
  output logic [PW-1:0]             cur_player,
  output logic [TW-1:0]             throw_idx,
  output logic [NUM_PLAYERS*SW-1:0] totals,
  output logic                      game_over,
  output logic [PW-1:0]             winner,
  output logic                      bust
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam int          CI    = 2 ** (W - 1);
  localparam logic [W:0]  C     = (W + 1)'(CI);
  localparam logic [W:0]  MAXC  = (W + 1)'((2 ** W) - 1);
  localparam logic [SW:0] TGT   = (SW + 1)'(TARGET);

  state_t         state;
  logic [SW-1:0]  tot [NUM_PLAYERS];

  // Cell score: Manhattan distance from the board centre, subtracted from the max score.
  logic [W:0]     xe, ye, dx, dy, score_w;
  logic [W-1:0]   score;
  logic [SW-1:0]  cur_tot;
  logic [SW:0]    sum;
  logic [SW-1:0]  sat_tot;
  logic [PW-1:0]  nxt_player;
  logic           turn_end;

  assign xe      = {1'b0, throw_x};
  assign ye      = {1'b0, throw_y};
  assign dx      = (xe >= C) ? (xe - C) : (C - xe);
  assign dy      = (ye >= C) ? (ye - C) : (C - ye);
  assign score_w = (throw_x == '0 || throw_y == '0) ? '0 : (MAXC - dx - dy);
  assign score   = score_w[W-1:0];

  assign cur_tot    = tot[cur_player];
  assign sum        = {1'b0, cur_tot} + (SW + 1)'(score);
  assign sat_tot    = sum[SW] ? '1 : sum[SW-1:0];
  assign nxt_player = (cur_player == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player + 1'b1;
  assign turn_end   = (throw_idx == TW'(THROWS_PER_TURN - 1));

  assign throw_ready = (state == PLAY);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pack
    assign totals[p*SW +: SW] = tot[p];
  end

`ifdef DART_SCOREBOARD_BUST_EN
  logic [SW-1:0] turn_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      for (int p = 0; p < NUM_PLAYERS; p++) tot[p] <= '0;
      last_valid <= 1'b0;
      last_score <= '0;
      cur_player <= '0;
      throw_idx  <= '0;
      game_over  <= 1'b0;
      winner     <= '0;
      bust       <= 1'b0;
      turn_base  <= '0;
    end else begin
      last_valid <= 1'b0;
      bust       <= 1'b0;
      if (state != PLAY) begin
        if (start) begin
          state      <= PLAY;
          for (int p = 0; p < NUM_PLAYERS; p++) tot[p] <= '0;
          last_score <= '0;
          cur_player <= '0;
          throw_idx  <= '0;
          game_over  <= 1'b0;
          winner     <= '0;
          turn_base  <= '0;
        end
      end else if (throw_valid) begin
        last_valid <= 1'b1;
        last_score <= score;
        if (sum > TGT) begin
          // Overshoot: restore the turn's opening total and hand over immediately.
          bust            <= 1'b1;
          tot[cur_player] <= turn_base;
          throw_idx       <= '0;
          cur_player      <= nxt_player;
          turn_base       <= tot[nxt_player];
        end else begin
          tot[cur_player] <= sum[SW-1:0];
          if (sum == TGT) begin
            state     <= OVER;
            game_over <= 1'b1;
            winner    <= cur_player;
          end else if (turn_end) begin
            throw_idx  <= '0;
            cur_player <= nxt_player;
            turn_base  <= tot[nxt_player];
          end else begin
            throw_idx <= throw_idx + 1'b1;
          end
        end
      end
    end
  end
`else
  assign bust = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      for (int p = 0; p < NUM_PLAYERS; p++) tot[p] <= '0;
      last_valid <= 1'b0;
      last_score <= '0;
      cur_player <= '0;
      throw_idx  <= '0;
      game_over  <= 1'b0;
      winner     <= '0;
    end else begin
      last_valid <= 1'b0;
      if (state != PLAY) begin
        if (start) begin
          state      <= PLAY;
          for (int p = 0; p < NUM_PLAYERS; p++) tot[p] <= '0;
          last_score <= '0;
          cur_player <= '0;
          throw_idx  <= '0;
          game_over  <= 1'b0;
          winner     <= '0;
        end
      end else if (throw_valid) begin
        last_valid      <= 1'b1;
        last_score      <= score;
        tot[cur_player] <= sat_tot;
        if ({1'b0, sat_tot} >= TGT) begin
          state     <= OVER;
          game_over <= 1'b1;
          winner    <= cur_player;
        end else if (turn_end) begin
          throw_idx  <= '0;
          cur_player <= nxt_player;
        end else begin
          throw_idx <= throw_idx + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dart_scoreboard.sv
// Randomised bench for dart_scoreboard with a rule-level reference model.
module tb_dart_scoreboard;
  localparam int W   = 2;
  localparam int NP  = 2;
  localparam int TPT = 3;
  localparam int TGT = 21;
  localparam int SW  = 8;
  localparam int PW  = 1;
  localparam int TW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0, start = 1'b0, throw_valid = 1'b0;
  logic [W-1:0]      throw_x = '0, throw_y = '0;
  logic              throw_ready, last_valid, game_over, bust;
  logic [W-1:0]      last_score;
  logic [PW-1:0]     cur_player, winner;
  logic [TW-1:0]     throw_idx;
  logic [NP*SW-1:0]  totals;

  dart_scoreboard #(.W(W), .NUM_PLAYERS(NP), .THROWS_PER_TURN(TPT), .TARGET(TGT), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .throw_valid(throw_valid),
    .throw_x(throw_x), .throw_y(throw_y), .throw_ready(throw_ready),
    .last_valid(last_valid), .last_score(last_score), .cur_player(cur_player),
    .throw_idx(throw_idx), .totals(totals), .game_over(game_over),
    .winner(winner), .bust(bust)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: game state as plain integers.
  int m_mode;  // 0 idle, 1 playing, 2 over
  int m_tot[NP];
  int m_last, m_lv, m_cp, m_ti, m_go, m_win, m_bust, m_base;

  function automatic int cell_score(input int x, input int y);
    int c, ax, ay;
    c = 2 ** (W - 1);
    if (x == 0 || y == 0) return 0;
    ax = (x > c) ? x - c : c - x;
    ay = (y > c) ? y - c : c - y;
    return (2 ** W - 1) - (ax + ay);
  endfunction

  function automatic void next_turn();
    m_ti   = 0;
    m_cp   = (m_cp + 1) % NP;
    m_base = m_tot[m_cp];
  endfunction

  function automatic void new_game();
    foreach (m_tot[p]) m_tot[p] = 0;
    m_last = 0; m_cp = 0; m_ti = 0; m_go = 0; m_win = 0; m_base = 0;
  endfunction

  function automatic void model(input bit r, input bit s, input bit v, input int x, input int y);
    int sc, nt;
    m_lv = 0; m_bust = 0;
    if (r) begin
      new_game();
      m_mode = 0;
    end else if (m_mode != 1) begin
      if (s) begin
        new_game();
        m_mode = 1;
      end
    end else if (v) begin
      sc = cell_score(x, y);
      m_lv = 1; m_last = sc;
      nt = m_tot[m_cp] + sc;
`ifdef DART_SCOREBOARD_BUST_EN
      if (nt > TGT) begin
        m_bust = 1;
        m_tot[m_cp] = m_base;
        next_turn();
      end else begin
        m_tot[m_cp] = nt;
        if (nt == TGT) begin
          m_mode = 2; m_go = 1; m_win = m_cp;
        end else if (m_ti == TPT - 1) next_turn();
        else m_ti++;
      end
`else
      if (nt > 2 ** SW - 1) nt = 2 ** SW - 1;
      m_tot[m_cp] = nt;
      if (nt >= TGT) begin
        m_mode = 2; m_go = 1; m_win = m_cp;
      end else if (m_ti == TPT - 1) next_turn();
      else m_ti++;
`endif
    end
  endfunction

  task automatic step(input bit r, input bit s, input bit v, input int x, input int y);
    rst = r; start = s; throw_valid = v;
    throw_x = W'(x); throw_y = W'(y);
    @(posedge clk);
    model(r, s, v, x, y);
    #1;
    check("ready", throw_ready, (m_mode == 1));
    check("last_valid", last_valid, m_lv);
    check("last_score", last_score, m_last);
    check("cur_player", cur_player, m_cp);
    check("throw_idx", throw_idx, m_ti);
    check("game_over", game_over, m_go);
    check("winner", winner, m_win);
    check("bust", bust, m_bust);
    for (int p = 0; p < NP; p++) check("total", totals[p*SW +: SW], m_tot[p]);
  endtask

  task automatic throw3(input int x, input int y);
    for (int i = 0; i < 3; i++) step(0, 0, 1, x, y);
  endtask

  initial begin
    // Reset and first throw at the centre.
    step(1, 0, 0, 0, 0);
    check("rst_ready", throw_ready, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 2, 2);
    check("tp_score3", last_score, 3);
    check("tp_tot3", totals[SW-1:0], 3);
    check("tp_idx1", throw_idx, 1);
    step(0, 0, 0, 0, 0);
    check("tp_lv_drop", last_valid, 0);

    // Off-board, corner and edge cells for player 0.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 3);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 3, 2);
    check("tp_tot_mix", totals[SW-1:0], 3);
    check("tp_cp1", cur_player, 1);

    // Full game to 21 by player 0, then a dropped throw.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    throw3(2, 2); throw3(0, 0); throw3(2, 2); throw3(0, 0);
`ifdef DART_SCOREBOARD_BUST_EN
    step(0, 0, 1, 1, 2);
    step(0, 0, 1, 2, 2);
    check("tp_bust", bust, 1);
    check("tp_bust_tot", totals[SW-1:0], 18);
    check("tp_bust_cp", cur_player, 1);
`else
    step(0, 0, 1, 2, 2);
    check("tp_win_tot", totals[SW-1:0], 21);
    check("tp_game_over", game_over, 1);
    check("tp_winner", winner, 0);
    step(0, 0, 1, 2, 2);
    check("tp_frozen", totals[SW-1:0], 21);
`endif

    // Throw held across start in IDLE.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 2, 2);
    step(0, 1, 1, 2, 2);
    check("tp_start_nothrow", last_valid, 0);
    step(0, 0, 1, 2, 2);
    check("tp_after_start", totals[SW-1:0], 3);

    // Reset mid-turn with player 1 at 5.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    throw3(0, 0);
    step(0, 0, 1, 2, 2);
    step(0, 0, 1, 1, 2);
    check("tp_p1_5", totals[2*SW-1:SW], 5);
    step(1, 0, 1, 2, 2);
    check("tp_rst_p1", totals[2*SW-1:SW], 0);
    step(0, 1, 0, 0, 0);
    check("tp_fresh_cp", cur_player, 0);

    // Random play.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(299) == 0), ($urandom_range(24) == 0), ($urandom_range(9) < 7),
           $urandom_range(3), $urandom_range(3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dart_scoreboard.md
Name: dart_scoreboard

Overview:
- Sequential, parametrised successor to the team's combinational dart-cell scorer.
- Scores each throw on a (2^W)x(2^W) coordinate grid and accumulates per-player totals over turns of fixed length.
- Rotates players between turns and detects the winner.
- Sits between the throw-input front end (switches or sensor decoder) and the display/LED driver.

Parameters:
- W, 2, coordinate width. Board cells are 1..2^W-1 on each axis; coordinate 0 is off-board.
- NUM_PLAYERS, 2, number of players (>=2).
- THROWS_PER_TURN, 3, throws per player turn (>=1).
- TARGET, 21, winning total.
- SW, 8, per-player total width. TARGET must be less than 2^SW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  begin a new game.
- throw_valid  in  1  throw offered.
- throw_x  in  W  throw column.
- throw_y  in  W  throw row.
- throw_ready  out  1  throw can be accepted.
- last_valid  out  1  one-cycle pulse: last_score and totals reflect a new throw.
- last_score  out  W  score of the last accepted throw.
- cur_player  out  max(1,clog2(NUM_PLAYERS))  player to throw.
- throw_idx  out  max(1,clog2(THROWS_PER_TURN))  throw index within the turn.
- totals  out  NUM_PLAYERS*SW  packed totals; player p occupies bits [p*SW +: SW].
- game_over  out  1  a winner has been decided.
- winner  out  max(1,clog2(NUM_PLAYERS))  winning player, valid while game_over=1.
- bust  out  1  one-cycle pulse on a bust (feature only; otherwise tied 0).

Behaviour:
- Cell score rule:
  - C = 2^(W-1); if x==0 or y==0, score = 0.
  - Otherwise d = |x-C| + |y-C| and score = (2^W-1) - d, which is never negative on-board.
  - For W=2: (2,2)=3, (1,2)=(2,1)=(2,3)=(3,2)=2, (1,1)=(1,3)=(3,1)=(3,3)=1, any 0 coordinate = 0.
- Reset (sync, rst=1 at edge):
  - state=IDLE.
  - All totals=0, last_score=0, last_valid=0, cur_player=0, throw_idx=0.
  - game_over=0, winner=0, bust=0.
- FSM states:
  - IDLE: throw_ready=0. start -> PLAY.
  - PLAY: throw_ready=1. Winning throw -> OVER. start ignored.
  - OVER: throw_ready=0, game_over=1. start -> PLAY.
- Entering PLAY via start: totals, cur_player, throw_idx, game_over, winner and last_score all cleared at the same edge.
- Handshake:
  - A throw is accepted on an edge where throw_valid && throw_ready.
  - throw_valid while throw_ready=0 is dropped, with no side effects.
  - start and throw_valid in the same IDLE/OVER cycle: start wins; the throw is not accepted.
- Latency: 1 cycle. At the accepting edge, last_score, the cur_player total and last_valid=1 all update together. last_valid deasserts next cycle unless another throw is accepted.
- Throws may be accepted back-to-back, one per cycle.
- Accumulation: total += score, saturating at 2^SW-1.
- Turn advance:
  - throw_idx increments after each accepted throw.
  - At THROWS_PER_TURN-1 it wraps to 0 and cur_player advances, wrapping NUM_PLAYERS-1 -> 0.
- Win:
  - If the updated total >= TARGET: state -> OVER, game_over=1, winner = throwing player.
  - cur_player and throw_idx freeze at the accepting edge; throw_ready=0 from the next cycle.
- Reset mid-game takes priority over every other event and yields the reset values.

Optional Feature:
- Macro: DART_SCOREBOARD_BUST_EN.
- Defined (exact-finish rule):
  - A turn_base register per current turn holds the thrower's total at the start of the turn.
  - If total + score > TARGET, the total reverts to turn_base and bust pulses for 1 cycle.
  - On a bust, the turn ends immediately (throw_idx=0, next player); last_score still shows the raw score.
  - Win only when the total == TARGET exactly.
- Undefined: no turn_base register, bust tied 0, and the >= TARGET win rule applies.

Test Plan:
- Reset, start, throw (2,2) -> next cycle last_valid=1, last_score=3, totals[7:0]=3, throw_idx=1; a cycle later last_valid=0.
- Throws (0,3),(1,1),(3,2) by player 0 -> scores 0,1,2, total 3, then cur_player=1, throw_idx=0.
- P0 plays 3x(2,2), P1 plays 3x(0,0), P0 plays 3x(2,2), P1 plays 3x(0,0), then P0 plays (2,2) -> total 21, game_over=1, winner=0, throw_ready=0; a further throw_valid leaves totals unchanged.
- throw_valid held in IDLE, then start -> no throw counted on the start cycle; the throw is accepted the cycle after.
- rst pulsed mid-turn with P1 at total 5 -> all totals 0, state IDLE, throw_ready=0; start resumes a fresh game with player 0.
- BUST_EN defined: P0 at 18 throws (1,2)->20, then (2,2)->23 -> bust=1, P0 total back to 18, cur_player=1, throw_idx=0.
